// File: rtl/enemy_spawner_pkg.sv
// Shared game constants for the enemy spawner: slot map, playfield limit,
// default pacing and FSM state encoding.
package enemy_spawner_pkg;

  localparam int SLOTS       = 23;
  localparam int FLY_BASE    = 0;
  localparam int SPIDER_BASE = 17;
  localparam int MOSQ_BASE   = 21;
  localparam int X_MAX       = 600;
  localparam int GAP_FRAMES  = 30;

  localparam int ID_W  = 5;
  localparam int X_W   = 10;
  localparam int CNT_W = 16;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_OFFER = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

endpackage

// File: rtl/lfsr10.sv
// 10-bit maximal-length Fibonacci LFSR, polynomial x^10 + x^7 + 1.
// Seeded with 1 so the all-zero lock-up state is never reached.
module lfsr10 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic [9:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= 10'h001;
    end else if (enable) begin
      state <= {state[8:0], state[9] ^ state[6]};
    end
  end

endmodule

// File: rtl/enemy_spawner.sv
// Round-robin enemy spawner: scans slots for a free, enabled enemy, offers it
// with a random x position over a valid/ready handshake, then waits out a gap.
module enemy_spawner
  import enemy_spawner_pkg::*;
#(
  parameter int SLOTS      = enemy_spawner_pkg::SLOTS,
  parameter int GAP_FRAMES = enemy_spawner_pkg::GAP_FRAMES,
  parameter int X_MAX      = enemy_spawner_pkg::X_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             run,
  input  logic [SLOTS-1:0] enable_enemy,
  input  logic [SLOTS-1:0] enemy_alive,
  output logic             spawn_valid,
  output logic [4:0]       spawn_id,
  output logic [9:0]       spawn_x,
  input  logic             spawn_ready,
  output logic [15:0]      spawn_count
);

  localparam int GAP_W = (GAP_FRAMES > 0) ? $clog2(GAP_FRAMES + 1) : 1;

  state_t           state;
  logic [4:0]       ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic             armed;
  logic [9:0]       lfsr_q;
  logic [SLOTS-1:0] elig;

  assign elig = enable_enemy & ~enemy_alive;

  lfsr10 u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (1'b1),
    .state  (lfsr_q)
  );

  // Single-subtraction fold keeps the result inside 0..X_MAX for X_MAX >= 511.
  function automatic logic [9:0] fold_x(input logic [9:0] v);
    if (v > 10'(X_MAX)) return v - 10'(X_MAX) - 10'd1;
    return v;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic logic [4:0] next_slot(input logic [4:0] s);
    return (s == 5'(SLOTS - 1)) ? 5'd0 : s + 5'd1;
  endfunction

  // armed holds IDLE for one extra edge after reset release so the first
  // request cannot appear before the third clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= 5'd0;
      gap_cnt     <= '0;
      armed       <= 1'b0;
      spawn_valid <= 1'b0;
      spawn_id    <= 5'd0;
      spawn_x     <= 10'd0;
      spawn_count <= 16'd0;
    end else begin
      armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (run && armed) state <= ST_SCAN;
        end
        ST_SCAN: begin
          if (!run) begin
            state <= ST_IDLE;
          end else if (elig[ptr]) begin
            state       <= ST_OFFER;
            spawn_valid <= 1'b1;
            spawn_id    <= ptr;
            spawn_x     <= fold_x(lfsr_q);
          end else begin
            ptr <= next_slot(ptr);
          end
        end
        ST_OFFER: begin
          // An accept in the same cycle beats a withdrawal.
          if (spawn_ready) begin
            spawn_valid <= 1'b0;
            spawn_count <= sat_inc(spawn_count);
            ptr         <= next_slot(spawn_id);
            gap_cnt     <= GAP_W'(GAP_FRAMES);
            state       <= run ? ST_GAP : ST_IDLE;
          end else if (!elig[spawn_id]) begin
            spawn_valid <= 1'b0;
            state       <= run ? ST_SCAN : ST_IDLE;
          end
        end
        ST_GAP: begin
          if (!run) begin
            state <= ST_IDLE;
          end else if (gap_cnt == '0) begin
            state <= ST_SCAN;
          end else if (frame_tick) begin
            gap_cnt <= gap_cnt - 1'b1;
            if (gap_cnt == GAP_W'(1)) state <= ST_SCAN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/enemy_spawner.md
ENEMY_SPAWNER -- requirements
Module: enemy_spawner

Interface
REQ-001 Parameter SLOTS, default 23, number of enemy slots (indices 0-16 Fly, 17-20 Spider, 21-22 Mosquito).
REQ-002 Parameter GAP_FRAMES, default 30, minimum frame ticks between two spawns.
REQ-003 Parameter X_MAX, default 600, largest legal spawn x coordinate.
REQ-004 clk  in  1  system clock, single clock domain.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 frame_tick  in  1  one-cycle pulse per video frame.
REQ-007 run  in  1  1 = game running; 0 = hold, no new spawns.
REQ-008 enable_enemy  in  SLOTS  per-slot permission mask from stage control.
REQ-009 enemy_alive  in  SLOTS  per-slot alive status from enemy instances.
REQ-010 spawn_valid  out  1  spawn request pending.
REQ-011 spawn_id  out  5  slot index of pending request.
REQ-012 spawn_x  out  10  horizontal spawn position, 0..X_MAX.
REQ-013 spawn_ready  in  1  enemy side accepts request.
REQ-014 spawn_count  out  16  total accepted spawns, saturating.

Function
REQ-015 Slot i is eligible when enable_enemy[i]=1 and enemy_alive[i]=0.
REQ-016 FSM states: IDLE, SCAN, OFFER, GAP.
REQ-017 IDLE -> SCAN when run=1; any state except OFFER -> IDLE when run=0.
REQ-018 SCAN examines one slot per cycle starting at round-robin pointer ptr; pointer wraps SLOTS-1 -> 0.
REQ-019 Eligible slot found in SCAN -> OFFER next cycle, spawn_id=slot, spawn_x latched from LFSR.
REQ-020 Full SLOTS-cycle sweep with no eligible slot -> remain SCAN, restart sweep; no spawn_valid.
REQ-021 OFFER: spawn_valid=1; spawn_id, spawn_x stable until spawn_valid&spawn_ready.
REQ-022 Handshake completes in the cycle spawn_valid=1 and spawn_ready=1; next cycle spawn_valid=0, state GAP, ptr=spawn_id+1 (wrapped), spawn_count+1 (saturates 16'hFFFF).
REQ-023 OFFER withdrawn (-> SCAN, spawn_valid=0 next cycle, no count) if enable_enemy[spawn_id]=0 or enemy_alive[spawn_id]=1 without ready in same cycle; ready in that cycle wins.
REQ-024 run=0 during OFFER: request held until accepted or withdrawn per REQ-023, then IDLE.
REQ-025 GAP: counter loads GAP_FRAMES on entry, decrements on frame_tick, -> SCAN when it reaches 0 with tick; GAP_FRAMES=0 -> SCAN next cycle.
REQ-026 spawn_x: 10-bit maximal-length LFSR (taps x^10+x^7+1), advances every clk, never zero; value > X_MAX folded to value-X_MAX-1 (single subtraction).
REQ-027 spawn_valid is registered; no combinational path ready -> valid.

Reset
REQ-028 rst_n=0 asynchronously forces: state IDLE, ptr 0, gap counter 0, spawn_valid 0, spawn_id 0, spawn_x 0, spawn_count 0, LFSR 10'h001.
REQ-029 Reset mid-OFFER drops request immediately, no count increment; first valid after release no earlier than third clk edge.

Structure
REQ-030 Shared game package holds SLOTS, slot-range constants (FLY_BASE 0, SPIDER_BASE 17, MOSQ_BASE 21), X_MAX and state encoding.
REQ-031 One sub-module lfsr10 (enable, 10-bit state out); rest flat. Target 150-300 lines RTL.

Verification
REQ-032 Reset, run=1, enable=23'h1FFFF, alive=0, ready=1 -> ids 0,1,2 in order, each separated by GAP_FRAMES frame ticks; count=3.
REQ-033 alive=all 1 -> spawn_valid stays 0 for 1000 cycles; then clear alive[5] -> spawn_id=5 within SLOTS+1 cycles.
REQ-034 ready=0 for 20 cycles during OFFER -> spawn_id, spawn_x constant, valid held; ready=1 -> one count, GAP entered.
REQ-035 OFFER id=18, drop enable_enemy[18] with ready=0 -> valid=0 next cycle, count unchanged, rescan.
REQ-036 ptr=22 eligible, accept -> next scan starts at 0 (wrap); 1000 spawns -> all spawn_x <= X_MAX, none stuck.
REQ-037 rst_n low for 1 cycle asynchronously mid-OFFER -> valid=0 and count=0 without clock edge.
